// File: rtl/lane_tx_scheduler_if.sv
// Lane scheduler bus: two lane byte streams in, scheduled byte slot and lane status out.
// No storage or latency of its own; master drives lane bytes and pause, slave returns the slot.
// Backpressure comes only from pause (downstream) and is reported upstream via afull/overflow.
interface lane_tx_scheduler_if;
    logic [7:0] data_0;
    logic       valid_0;
    logic [7:0] data_1;
    logic       valid_1;
    logic       pause;
    logic [7:0] data_out;
    logic       valid_out;
    logic       grant;
    logic       afull_0;
    logic       afull_1;
    logic       overflow_0;
    logic       overflow_1;

    modport master (
        output data_0, valid_0, data_1, valid_1, pause,
        input  data_out, valid_out, grant, afull_0, afull_1, overflow_0, overflow_1
    );

    modport slave (
        input  data_0, valid_0, data_1, valid_1, pause,
        output data_out, valid_out, grant, afull_0, afull_1, overflow_0, overflow_1
    );
endinterface

// File: rtl/lane_tx_scheduler.sv
// Generic synchronous FIFO: a push is written at the edge, the head is readable the next cycle.
// Latency: 1 edge from push to head visible.
// Backpressure: a push while full is ignored; a pop while empty is ignored.
module lane_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign push_ok  = push && !full;
    assign pop_ok   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end
endmodule

// Two-lane byte scheduler: per-lane FIFOs, round-robin grant of one output byte slot, idle fill.
// Latency: byte pushed at edge k into an empty, uncontested lane is on data_out after edge k+1.
// Backpressure: pause holds the output and pops nothing; pushes continue, drops set sticky overflow.
module lane_tx_scheduler #(
    parameter int          DEPTH     = 4,
    parameter int          AF_THRESH = 3,
    parameter logic [7:0]  IDLE_SYM  = 8'hBC
) (
    input  logic                 clk_2f,
    input  logic                 reset_L,
    lane_tx_scheduler_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] cnt_0, cnt_1;
    logic [CW-1:0] cnt_nxt_0, cnt_nxt_1;
    logic [7:0]    head_0, head_1;
    logic          full_0, full_1;
    logic          elig_0, elig_1;
    logic          push_0, push_1;
    logic          pop_0, pop_1;
    logic          win;
    logic          last_grant;

    logic [7:0]    data_out_q;
    logic          valid_out_q;
    logic          grant_q;
    logic          afull_0_q, afull_1_q;
    logic          overflow_0_q, overflow_1_q;

    lane_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo_0 (
        .clk      (clk_2f),
        .rst_n    (reset_L),
        .push     (push_0),
        .push_dat (bus.data_0),
        .pop      (pop_0),
        .head_dat (head_0),
        .count    (cnt_0),
        .full     (full_0)
    );

    lane_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo_1 (
        .clk      (clk_2f),
        .rst_n    (reset_L),
        .push     (push_1),
        .push_dat (bus.data_1),
        .pop      (pop_1),
        .head_dat (head_1),
        .count    (cnt_1),
        .full     (full_1)
    );

    // Eligibility uses pre-edge counts, so a byte pushed this edge waits one cycle.
    always_comb begin
        elig_0    = (cnt_0 != '0);
        elig_1    = (cnt_1 != '0);
        win       = (elig_0 && elig_1) ? ~last_grant : elig_1;
        pop_0     = !bus.pause && elig_0 && !win;
        pop_1     = !bus.pause && elig_1 && win;
        push_0    = bus.valid_0 && !full_0;
        push_1    = bus.valid_1 && !full_1;
        cnt_nxt_0 = cnt_0 + CW'(push_0) - CW'(pop_0);
        cnt_nxt_1 = cnt_1 + CW'(push_1) - CW'(pop_1);
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            data_out_q   <= 8'h00;
            valid_out_q  <= 1'b0;
            grant_q      <= 1'b0;
            last_grant   <= 1'b1;
            afull_0_q    <= 1'b0;
            afull_1_q    <= 1'b0;
            overflow_0_q <= 1'b0;
            overflow_1_q <= 1'b0;
        end else begin
            afull_0_q <= (cnt_nxt_0 >= CW'(AF_THRESH));
            afull_1_q <= (cnt_nxt_1 >= CW'(AF_THRESH));
            if (bus.valid_0 && full_0) overflow_0_q <= 1'b1;
            if (bus.valid_1 && full_1) overflow_1_q <= 1'b1;
            if (!bus.pause) begin
                if (elig_0 || elig_1) begin
                    data_out_q  <= win ? head_1 : head_0;
                    valid_out_q <= 1'b1;
                    grant_q     <= win;
                    last_grant  <= win;
                end else begin
                    data_out_q  <= IDLE_SYM;
                    valid_out_q <= 1'b0;
                end
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.grant      = grant_q;
    assign bus.afull_0    = afull_0_q;
    assign bus.afull_1    = afull_1_q;
    assign bus.overflow_0 = overflow_0_q;
    assign bus.overflow_1 = overflow_1_q;
endmodule

// File: tb/tb_lane_tx_scheduler.sv
// Bench for lane_tx_scheduler: queue-based lane model compared every cycle, directed
// scenarios pinned with literal values, then bursty randomized traffic with random pause.
module tb_lane_tx_scheduler;
    localparam int         DEPTH = 4;
    localparam int         AF    = 3;
    localparam logic [7:0] IDLE  = 8'hBC;

    logic clk_2f  = 1'b0;
    logic reset_L = 1'b1;

    lane_tx_scheduler_if bus();

    lane_tx_scheduler #(.DEPTH(DEPTH), .AF_THRESH(AF), .IDLE_SYM(IDLE)) dut (
        .clk_2f  (clk_2f),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    always #5 clk_2f = ~clk_2f;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: lanes are queues, the slot goes to the other lane when both hold data.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       m_last  = 1'b1;
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_grant = 1'b0;
    logic       m_af0 = 1'b0, m_af1 = 1'b0;
    logic       m_ov0 = 1'b0, m_ov1 = 1'b0;
    int         m_s0, m_s1;
    logic       m_w;

    always @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            q0.delete();
            q1.delete();
            m_last = 1'b1; m_data = 8'h00; m_valid = 1'b0; m_grant = 1'b0;
            m_af0 = 1'b0; m_af1 = 1'b0; m_ov0 = 1'b0; m_ov1 = 1'b0;
        end else begin
            m_s0 = q0.size();
            m_s1 = q1.size();
            if (!bus.pause) begin
                if (m_s0 > 0 || m_s1 > 0) begin
                    if (m_s0 > 0 && m_s1 > 0) m_w = ~m_last;
                    else                      m_w = (m_s1 > 0);
                    if (m_w) m_data = q1.pop_front();
                    else     m_data = q0.pop_front();
                    m_valid = 1'b1;
                    m_grant = m_w;
                    m_last  = m_w;
                end else begin
                    m_data  = IDLE;
                    m_valid = 1'b0;
                end
            end
            if (bus.valid_0) begin
                if (m_s0 < DEPTH) q0.push_back(bus.data_0);
                else              m_ov0 = 1'b1;
            end
            if (bus.valid_1) begin
                if (m_s1 < DEPTH) q1.push_back(bus.data_1);
                else              m_ov1 = 1'b1;
            end
            m_af0 = (q0.size() >= AF);
            m_af1 = (q1.size() >= AF);
        end
    end

    always @(negedge clk_2f) begin
        if (chk_en) begin
            chk8("data_out",   bus.data_out,   m_data);
            chk1("valid_out",  bus.valid_out,  m_valid);
            chk1("grant",      bus.grant,      m_grant);
            chk1("afull_0",    bus.afull_0,    m_af0);
            chk1("afull_1",    bus.afull_1,    m_af1);
            chk1("overflow_0", bus.overflow_0, m_ov0);
            chk1("overflow_1", bus.overflow_1, m_ov1);
        end
    end

    task automatic drv(input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic p);
        bus.valid_0 = v0;
        bus.data_0  = d0;
        bus.valid_1 = v1;
        bus.data_1  = d1;
        bus.pause   = p;
    endtask

    int rate0, rate1, prate;

    initial begin
        drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        #2 reset_L = 1'b0;
        chk_en = 1'b1;

        // Reset, then idle
        repeat (3) @(negedge clk_2f);
        chk8("rst_data", bus.data_out, 8'h00);
        chk1("rst_valid", bus.valid_out, 1'b0);
        #1 reset_L = 1'b1;
        @(negedge clk_2f);
        chk8("idle_data", bus.data_out, 8'hBC);
        chk1("idle_valid", bus.valid_out, 1'b0);
        chk1("idle_grant", bus.grant, 1'b0);

        // Interleave: both lanes push at the same edge, lane 0 wins first
        #1 drv(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b0);
        @(negedge clk_2f); #1 drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk_2f);
        chk8("ilv_first", bus.data_out, 8'hA0);
        chk1("ilv_first_grant", bus.grant, 1'b0);
        chk1("ilv_first_valid", bus.valid_out, 1'b1);
        @(negedge clk_2f);
        chk8("ilv_second", bus.data_out, 8'hB0);
        chk1("ilv_second_grant", bus.grant, 1'b1);
        @(negedge clk_2f);
        chk8("ilv_idle", bus.data_out, 8'hBC);
        chk1("ilv_idle_valid", bus.valid_out, 1'b0);

        // Single-lane burst, no idle gaps
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_2f);
            if (i >= 2) chk8("burst", bus.data_out, 8'(i - 1));
            #1 drv(1'b1, 8'(i + 1), 1'b0, 8'h00, 1'b0);
        end
        @(negedge clk_2f);
        chk8("burst", bus.data_out, 8'h03);
        #1 drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk_2f);
        chk8("burst", bus.data_out, 8'h04);
        chk1("burst_grant", bus.grant, 1'b0);
        chk1("burst_valid", bus.valid_out, 1'b1);
        @(negedge clk_2f);
        chk8("burst_end", bus.data_out, 8'hBC);

        // Overflow and afull on lane 1 while paused
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_2f);
            if (i == 2) chk1("afull_after2", bus.afull_1, 1'b0);
            if (i == 3) chk1("afull_after3", bus.afull_1, 1'b1);
            if (i == 4) chk1("ovf_after4", bus.overflow_1, 1'b0);
            #1 drv(1'b0, 8'h00, 1'b1, 8'(8'h31 + i), 1'b1);
        end
        @(negedge clk_2f);
        chk1("ovf_after5", bus.overflow_1, 1'b1);
        chk1("ovf_lane0_clean", bus.overflow_0, 1'b0);
        #1 drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk_2f);
            chk8("ovf_drain", bus.data_out, 8'(8'h31 + j));
            chk1("ovf_drain_grant", bus.grant, 1'b1);
        end
        @(negedge clk_2f);
        chk8("ovf_drain_end", bus.data_out, 8'hBC);
        chk1("ovf_sticky", bus.overflow_1, 1'b1);

        // Pause hold while 22 is on the output
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_2f);
            #1 drv(1'b1, 8'(8'h21 + i), 1'b0, 8'h00, 1'b0);
        end
        @(negedge clk_2f);
        chk8("pre_pause", bus.data_out, 8'h22);
        #1 drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (3) begin
            @(negedge clk_2f);
            chk8("pause_data", bus.data_out, 8'h22);
            chk1("pause_valid", bus.valid_out, 1'b1);
            chk1("pause_grant", bus.grant, 1'b0);
        end
        #1 drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk_2f);
        chk8("post_pause", bus.data_out, 8'h23);
        @(negedge clk_2f);
        chk8("post_pause_idle", bus.data_out, 8'hBC);

        // Mid-stream asynchronous reset with two bytes held per lane
        #1 drv(1'b1, 8'h41, 1'b1, 8'h51, 1'b1);
        @(negedge clk_2f); #1 drv(1'b1, 8'h42, 1'b1, 8'h52, 1'b1);
        @(negedge clk_2f); #1 drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk_2f);
        #3 reset_L = 1'b0;
        #1;
        chk8("async_rst_data", bus.data_out, 8'h00);
        chk1("async_rst_valid", bus.valid_out, 1'b0);
        chk1("async_rst_ovf1", bus.overflow_1, 1'b0);
        chk1("async_rst_grant", bus.grant, 1'b0);
        @(negedge clk_2f);
        #1 drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        reset_L = 1'b1;
        @(negedge clk_2f);
        chk8("post_rst_data", bus.data_out, 8'hBC);
        chk1("post_rst_valid", bus.valid_out, 1'b0);
        repeat (3) begin
            @(negedge clk_2f);
            chk1("post_rst_empty", bus.valid_out, 1'b0);
        end

        // Bursty random traffic with random pause
        rate0 = 50; rate1 = 50; prate = 15;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                rate0 = int'($urandom_range(0, 100));
                rate1 = int'($urandom_range(0, 100));
                prate = int'($urandom_range(0, 60));
            end
            @(negedge clk_2f);
            #1 drv(($urandom_range(0, 99) < rate0), 8'($urandom),
                   ($urandom_range(0, 99) < rate1), 8'($urandom),
                   ($urandom_range(0, 99) < prate));
        end
        @(negedge clk_2f);
        #1 drv(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        repeat (12) @(negedge clk_2f);
        chk1("final_drained", bus.valid_out, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
